// File: rtl/p18_tone_sequencer.sv
// p18_tone_sequencer: NUM_CH independent square-wave tone channels mixed to one
// registered 1-bit sound output.
//   clk, rst    : clock, synchronous active-high reset
//   line_pulse  : one-cycle strobe per video line, tone timebase
//   frame_pulse : one-cycle strobe per frame, duration timebase
//   trig        : per-channel start strobe (ignored when that channel's dur is 0)
//   period      : packed half-periods in line strobes, channel i at [i*PER_W +: PER_W]
//   dur         : packed durations in frame strobes, channel i at [i*DUR_W +: DUR_W]
//   mute        : forces sound low, channels keep running
//   busy        : per-channel active flags (registered)
//   sound       : mixed square wave (registered)
module p18_tone_sequencer #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned PER_W    = 6,
  parameter int unsigned DUR_W    = 4,
  parameter int unsigned MIX_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      line_pulse,
  input  logic                      frame_pulse,
  input  logic [NUM_CH-1:0]         trig,
  input  logic [NUM_CH*PER_W-1:0]   period,
  input  logic [NUM_CH*DUR_W-1:0]   dur,
  input  logic                      mute,
  output logic [NUM_CH-1:0]         busy,
  output logic                      sound
);

  logic [NUM_CH-1:0][PER_W-1:0] period_q, period_d;
  logic [NUM_CH-1:0][PER_W-1:0] tone_cnt_q, tone_cnt_d;
  logic [NUM_CH-1:0][DUR_W-1:0] dur_cnt_q, dur_cnt_d;
  logic [NUM_CH-1:0]            phase_q, phase_d;
  logic [NUM_CH-1:0]            active_q, active_d;
  logic                         sound_q, sound_d;
  logic [NUM_CH-1:0]            wave_c;
  logic                         mix_c;

  // Per-channel next state: a valid trigger restarts the channel; otherwise an
  // active channel advances its tone counter on line strobes and its duration
  // counter on frame strobes. Expiry is applied last so it overrides the tone step.
  always_comb begin
    period_d   = period_q;
    tone_cnt_d = tone_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    phase_d    = phase_q;
    active_d   = active_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (trig[i] && (dur[i*DUR_W +: DUR_W] != '0)) begin
        period_d[i]   = period[i*PER_W +: PER_W];
        dur_cnt_d[i]  = dur[i*DUR_W +: DUR_W];
        tone_cnt_d[i] = '0;
        phase_d[i]    = 1'b0;
        active_d[i]   = 1'b1;
      end else if (active_q[i]) begin
        // A zero half-period is a rest: phase never leaves 0.
        if (line_pulse && (period_q[i] != '0)) begin
          if (tone_cnt_q[i] == period_q[i] - PER_W'(1)) begin
            tone_cnt_d[i] = '0;
            phase_d[i]    = ~phase_q[i];
          end else begin
            tone_cnt_d[i] = tone_cnt_q[i] + PER_W'(1);
          end
        end
        if (frame_pulse) begin
          if (dur_cnt_q[i] == DUR_W'(1)) begin
            active_d[i]   = 1'b0;
            phase_d[i]    = 1'b0;
            tone_cnt_d[i] = '0;
          end else begin
            dur_cnt_d[i] = dur_cnt_q[i] - DUR_W'(1);
          end
        end
      end
    end
  end

  // Channel mix of the current registered state.
  always_comb begin
    wave_c = active_q & phase_q;
    mix_c  = 1'b0;
    if (MIX_MODE == 1) begin
      mix_c = |wave_c;
    end else if (MIX_MODE == 2) begin
      // Walk downward so the lowest active index is the last writer.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (active_q[i]) begin
          mix_c = wave_c[i];
        end
      end
    end else begin
      mix_c = ^wave_c;
    end
    sound_d = mute ? 1'b0 : mix_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q   <= '0;
      tone_cnt_q <= '0;
      dur_cnt_q  <= '0;
      phase_q    <= '0;
      active_q   <= '0;
      sound_q    <= 1'b0;
    end else begin
      period_q   <= period_d;
      tone_cnt_q <= tone_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      phase_q    <= phase_d;
      active_q   <= active_d;
      sound_q    <= sound_d;
    end
  end

  assign busy  = active_q;
  assign sound = sound_q;

endmodule

// File: tb/tb_p18_tone_sequencer.sv
// Testbench for p18_tone_sequencer: three instances (XOR, OR, priority mix) share
// stimulus and are compared against a model that tracks, per channel, the number
// of line and frame strobes seen since the trigger.
module tb_p18_tone_sequencer;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned PER_W  = 6;
  localparam int unsigned DUR_W  = 4;
  localparam int unsigned OBS_W  = 3*NUM_CH + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, line_pulse, frame_pulse, mute;
  logic [NUM_CH-1:0]       trig;
  logic [NUM_CH*PER_W-1:0] period;
  logic [NUM_CH*DUR_W-1:0] dur;
  logic [NUM_CH-1:0]       busy_0, busy_1, busy_2;
  logic                    sound_0, sound_1, sound_2;
  logic [OBS_W-1:0]        obs_v, exp_v;

  p18_tone_sequencer #(.NUM_CH(NUM_CH), .PER_W(PER_W), .DUR_W(DUR_W), .MIX_MODE(0)) dut_xor (
    .clk(clk), .rst(rst), .line_pulse(line_pulse), .frame_pulse(frame_pulse), .trig(trig),
    .period(period), .dur(dur), .mute(mute), .busy(busy_0), .sound(sound_0));
  p18_tone_sequencer #(.NUM_CH(NUM_CH), .PER_W(PER_W), .DUR_W(DUR_W), .MIX_MODE(1)) dut_or (
    .clk(clk), .rst(rst), .line_pulse(line_pulse), .frame_pulse(frame_pulse), .trig(trig),
    .period(period), .dur(dur), .mute(mute), .busy(busy_1), .sound(sound_1));
  p18_tone_sequencer #(.NUM_CH(NUM_CH), .PER_W(PER_W), .DUR_W(DUR_W), .MIX_MODE(2)) dut_pri (
    .clk(clk), .rst(rst), .line_pulse(line_pulse), .frame_pulse(frame_pulse), .trig(trig),
    .period(period), .dur(dur), .mute(mute), .busy(busy_2), .sound(sound_2));

  assign obs_v = {busy_0, busy_1, busy_2, sound_0, sound_1, sound_2};

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int lp_div   = 4;
  int fp_div   = 64;

  // Model: strobes counted since trigger; phase = floor(lines/period) mod 2.
  int m_lcnt[NUM_CH];
  int m_fcnt[NUM_CH];
  int m_per[NUM_CH];
  int m_dur[NUM_CH];
  bit m_act[NUM_CH];

  function automatic bit m_wave(int i);
    return m_act[i] && (m_per[i] != 0) && (((m_lcnt[i] / m_per[i]) % 2) == 1);
  endfunction

  // Predict outputs after the coming edge, advance the model, then clock.
  task automatic tick();
    bit x, o, p, found, w;
    logic [NUM_CH-1:0] eb;
    x = 0; o = 0; p = 0; found = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      w = m_wave(i);
      x = x ^ w;
      o = o | w;
      if (!found && m_act[i]) begin
        p = w;
        found = 1;
      end
    end
    if (rst || mute) begin
      x = 0; o = 0; p = 0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        m_act[i] = 0; m_lcnt[i] = 0; m_fcnt[i] = 0; m_per[i] = 0; m_dur[i] = 0;
      end else if (trig[i] && (dur[i*DUR_W +: DUR_W] != 0)) begin
        m_act[i]  = 1;
        m_per[i]  = int'(period[i*PER_W +: PER_W]);
        m_dur[i]  = int'(dur[i*DUR_W +: DUR_W]);
        m_lcnt[i] = 0;
        m_fcnt[i] = 0;
      end else if (m_act[i]) begin
        if (line_pulse) m_lcnt[i]++;
        if (frame_pulse) begin
          m_fcnt[i]++;
          if (m_fcnt[i] >= m_dur[i]) m_act[i] = 0;
        end
      end
      eb[i] = m_act[i];
    end
    exp_v = {eb, eb, eb, x, o, p};
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic strobe_step();
    line_pulse  = (cyc % lp_div == 0);
    frame_pulse = (cyc % fp_div == 0);
    tick();
    line_pulse  = 0;
    frame_pulse = 0;
  endtask

  task automatic do_reset();
    rst = 1; trig = '0; mute = 0; line_pulse = 0; frame_pulse = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; trig = '0; mute = 0; line_pulse = 1; frame_pulse = 1;
    period = '1; dur = '1;
    tick();
    tick();
    n_checks++;
    if (obs_v !== '0) begin
      n_fails++;
      $display("FAIL reset_state: got %h expected 0", obs_v);
    end
    rst = 0; line_pulse = 0; frame_pulse = 0;
  endtask

  task automatic test_idle();
    lp_div = 4; fp_div = 64;
    for (int k = 0; k < 1000; k++) begin
      strobe_step();
      n_checks++;
      if (obs_v !== '0) begin
        n_fails++;
        $display("FAIL idle cyc=%0d: got %h expected 0", cyc, obs_v);
      end
    end
  endtask

  task automatic test_single_tone();
    int lines, nfr;
    bit prev_s, done, lp, fp;
    do_reset();
    lp_div = 4; fp_div = 64;
    period[0 +: PER_W] = PER_W'(3);
    dur[0 +: DUR_W]    = DUR_W'(2);
    trig = 4'b0001;
    tick();
    trig = '0;
    n_checks++;
    if (busy_1[0] !== 1'b1) begin
      n_fails++;
      $display("FAIL tone_start_busy: got %b expected 1", busy_1[0]);
    end
    lines = 0; nfr = 0; prev_s = sound_1; done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      lp = (cyc % lp_div == 0);
      fp = (cyc % fp_div == 0);
      strobe_step();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fails++;
        $display("FAIL tone_model cyc=%0d: got %h expected %h", cyc, obs_v, exp_v);
      end
      if (lp) lines++;
      if (fp) nfr++;
      if ((sound_1 !== prev_s) && busy_1[0]) begin
        n_checks++;
        if (lines % 3 != 0) begin
          n_fails++;
          $display("FAIL tone_toggle: got toggle after %0d lines expected multiple of 3", lines);
        end
      end
      prev_s = sound_1;
      if (!busy_1[0]) begin
        n_checks++;
        if (!fp || nfr != 2) begin
          n_fails++;
          $display("FAIL tone_expiry: got fall after %0d frames (on strobe=%0b) expected 2 (1)", nfr, fp);
        end
        done = 1;
      end
    end
    if (!done) begin
      n_checks++;
      n_fails++;
      $display("FAIL tone_timeout: got busy still 1 expected 0 within 400 cycles");
    end
    for (int k = 0; k < 3; k++) begin
      strobe_step();
      n_checks++;
      if ({sound_0, sound_1, sound_2} !== 3'b000) begin
        n_fails++;
        $display("FAIL tone_after: got %b expected 000", {sound_0, sound_1, sound_2});
      end
    end
  endtask

  task automatic test_zero_dur();
    do_reset();
    lp_div = 3; fp_div = 40;
    period[PER_W +: PER_W] = PER_W'(4);
    dur[DUR_W +: DUR_W]    = DUR_W'(0);
    trig = 4'b0010;
    tick();
    trig = '0;
    n_checks++;
    if (busy_1[1] !== 1'b0) begin
      n_fails++;
      $display("FAIL zero_dur_idle: got busy=%b expected 0", busy_1[1]);
    end
    dur[DUR_W +: DUR_W] = DUR_W'(5);
    trig = 4'b0010;
    tick();
    trig = '0;
    for (int k = 0; k < 30; k++) begin
      strobe_step();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fails++;
        $display("FAIL zero_dur_run cyc=%0d: got %h expected %h", cyc, obs_v, exp_v);
      end
    end
    period[PER_W +: PER_W] = PER_W'(9);
    dur[DUR_W +: DUR_W]    = DUR_W'(0);
    trig = 4'b0010;
    strobe_step();
    trig = '0;
    n_checks++;
    if (busy_1[1] !== 1'b1 || obs_v !== exp_v) begin
      n_fails++;
      $display("FAIL zero_dur_active: got %h expected %h with busy[1]=1", obs_v, exp_v);
    end
    for (int k = 0; k < 60; k++) begin
      strobe_step();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fails++;
        $display("FAIL zero_dur_cont cyc=%0d: got %h expected %h", cyc, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_mix_cancel();
    bit seen_or;
    do_reset();
    lp_div = 4; fp_div = 64;
    period[0 +: 2*PER_W] = {PER_W'(2), PER_W'(2)};
    dur[0 +: 2*DUR_W]    = {DUR_W'(3), DUR_W'(3)};
    trig = 4'b0011;
    tick();
    trig = '0;
    seen_or = 0;
    for (int k = 0; k < 120; k++) begin
      strobe_step();
      n_checks++;
      if (sound_0 !== 1'b0 || obs_v !== exp_v) begin
        n_fails++;
        $display("FAIL mix_cancel cyc=%0d: got %h (xor=%b) expected %h (xor=0)", cyc, obs_v, sound_0, exp_v);
      end
      if (sound_1) seen_or = 1;
    end
    n_checks++;
    if (!seen_or) begin
      n_fails++;
      $display("FAIL mix_or_wave: got or-mix never high expected square wave");
    end
  endtask

  task automatic test_priority();
    bit done;
    do_reset();
    lp_div = 2; fp_div = 32;
    period = '0; dur = '0;
    period[0 +: PER_W]       = PER_W'(2);
    dur[0 +: DUR_W]          = DUR_W'(1);
    period[2*PER_W +: PER_W] = PER_W'(5);
    dur[2*DUR_W +: DUR_W]    = DUR_W'(3);
    trig = 4'b0101;
    tick();
    trig = '0;
    done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      strobe_step();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fails++;
        $display("FAIL priority cyc=%0d: got %h expected %h", cyc, obs_v, exp_v);
      end
      if (busy_2 === '0) done = 1;
    end
    n_checks++;
    if (!done) begin
      n_fails++;
      $display("FAIL priority_timeout: got busy=%b expected 0 within 400 cycles", busy_2);
    end
  endtask

  task automatic test_trig_frame();
    do_reset();
    period[0 +: PER_W] = PER_W'(3);
    dur[0 +: DUR_W]    = DUR_W'(1);
    trig = 4'b0001;
    tick();
    trig = 4'b0001; frame_pulse = 1;
    tick();
    trig = '0; frame_pulse = 0;
    n_checks++;
    if (busy_0[0] !== 1'b1 || obs_v !== exp_v) begin
      n_fails++;
      $display("FAIL trig_frame_reload: got busy=%b expected 1", busy_0[0]);
    end
    frame_pulse = 1;
    tick();
    frame_pulse = 0;
    n_checks++;
    if (busy_0[0] !== 1'b0 || obs_v !== exp_v) begin
      n_fails++;
      $display("FAIL trig_frame_expire: got busy=%b expected 0", busy_0[0]);
    end
  endtask

  task automatic test_mute();
    logic [NUM_CH-1:0] b;
    bit hit;
    do_reset();
    lp_div = 4; fp_div = 64;
    period[0 +: PER_W] = PER_W'(1);
    dur[0 +: DUR_W]    = DUR_W'(3);
    trig = 4'b0001;
    tick();
    trig = '0;
    hit = 0;
    for (int k = 0; k < 50 && !hit; k++) begin
      strobe_step();
      if (sound_1) hit = 1;
    end
    n_checks++;
    if (!hit) begin
      n_fails++;
      $display("FAIL mute_setup: got sound never high expected high within 50 cycles");
    end
    b = busy_1;
    mute = 1;
    tick();
    n_checks++;
    if ({sound_0, sound_1, sound_2} !== 3'b000 || busy_1 !== b || obs_v !== exp_v) begin
      n_fails++;
      $display("FAIL mute: got sound=%b busy=%b expected 000 busy=%b", {sound_0, sound_1, sound_2}, busy_1, b);
    end
    mute = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    lp_div = 2; fp_div = 64;
    period = {PER_W'(3), PER_W'(2), PER_W'(1), PER_W'(1)};
    dur    = {DUR_W'(4), DUR_W'(4), DUR_W'(4), DUR_W'(4)};
    trig = '1;
    tick();
    trig = '0;
    for (int k = 0; k < 7; k++) strobe_step();
    rst = 1;
    tick();
    rst = 0;
    n_checks++;
    if (obs_v !== '0) begin
      n_fails++;
      $display("FAIL reset_mid: got %h expected 0", obs_v);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst         = ($urandom_range(0, 499) == 0);
      mute        = ($urandom_range(0, 9) == 0);
      line_pulse  = ($urandom_range(0, 2) == 0);
      frame_pulse = ($urandom_range(0, 24) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        trig[i] = ($urandom_range(0, 39) == 0);
        period[i*PER_W +: PER_W] = ($urandom_range(0, 9) == 0) ? PER_W'($urandom) : PER_W'($urandom_range(0, 6));
        dur[i*DUR_W +: DUR_W]    = DUR_W'($urandom_range(0, 6));
      end
      tick();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fails++;
        $display("FAIL random cyc=%0d: got %h expected %h", cyc, obs_v, exp_v);
      end
    end
    rst = 0; mute = 0; line_pulse = 0; frame_pulse = 0; trig = '0;
  endtask

  initial begin
    rst = 1; line_pulse = 0; frame_pulse = 0; mute = 0; trig = '0; period = '0; dur = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_act[i] = 0; m_lcnt[i] = 0; m_fcnt[i] = 0; m_per[i] = 0; m_dur[i] = 0;
    end
    test_reset();
    test_idle();
    test_single_tone();
    test_zero_dur();
    test_mix_cancel();
    test_priority();
    test_trig_frame();
    test_mute();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
